// File: rtl/pixel_shuffle_stream.sv
`timescale 1ns/1ps
// Depth-to-space stage: buffers one channel-major conv frame, then drains it
// upsampled by R in raster order through a registered-read frame buffer.
module pixel_shuffle_stream #(
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 2,
  parameter int IN_WIDTH     = 2,
  parameter int R            = 2,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  frame_done,
  output logic                  err
);

  localparam int CONV_CH = OUT_CHANNELS * R * R;
  localparam int N       = CONV_CH * IN_HEIGHT * IN_WIDTH;
  localparam int AW      = (N > 1) ? $clog2(N) : 1;
  localparam int CW      = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
  localparam int YOW     = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int XOW     = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int RW      = (R > 1) ? $clog2(R) : 1;

  typedef enum logic {LOAD = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  // Output y = yo*R + yi and x = xo*R + xi, kept split so no division is needed.
  logic [CW-1:0]   c_q, c_d;
  logic [YOW-1:0]  yo_q, yo_d;
  logic [RW-1:0]   yi_q, yi_d;
  logic [XOW-1:0]  xo_q, xo_d;
  logic [RW-1:0]   xi_q, xi_d;
  logic            err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [N];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [AW-1:0]         rd_addr;
  logic                  wr_en;
  logic                  s_fire, m_fire;
  logic                  last_beat, at_last;
  logic                  xi_max, xo_max, yi_max, yo_max, c_max;

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    c_d      = c_q;
    yo_d     = yo_q;
    yi_d     = yi_q;
    xo_d     = xo_q;
    xi_d     = xi_q;
    err_d    = err_q;

    xi_max    = (xi_q == RW'(R - 1));
    xo_max    = (xo_q == XOW'(IN_WIDTH - 1));
    yi_max    = (yi_q == RW'(R - 1));
    yo_max    = (yo_q == YOW'(IN_HEIGHT - 1));
    c_max     = (c_q == CW'(OUT_CHANNELS - 1));
    at_last   = xi_max && xo_max && yi_max && yo_max && c_max;
    last_beat = (wr_cnt_q == AW'(N - 1));

    s_ready    = (state_q == LOAD);
    m_valid    = (state_q == DRAIN);
    m_last     = m_valid && at_last;
    s_fire     = s_valid && s_ready;
    m_fire     = m_valid && m_ready;
    frame_done = m_fire && at_last;
    wr_en      = s_fire;

    if (state_q == LOAD) begin
      if (s_fire) begin
        if (s_last != last_beat) err_d = 1'b1;
        if (last_beat) begin
          wr_cnt_d = '0;
          state_d  = DRAIN;
        end else begin
          wr_cnt_d = wr_cnt_q + AW'(1);
        end
      end
    end else if (m_fire) begin
      if (at_last) begin
        c_d     = '0;
        yo_d    = '0;
        yi_d    = '0;
        xo_d    = '0;
        xi_d    = '0;
        state_d = LOAD;
      end else if (!xi_max) begin
        xi_d = xi_q + RW'(1);
      end else begin
        xi_d = '0;
        if (!xo_max) begin
          xo_d = xo_q + XOW'(1);
        end else begin
          xo_d = '0;
          if (!yi_max) begin
            yi_d = yi_q + RW'(1);
          end else begin
            yi_d = '0;
            if (!yo_max) begin
              yo_d = yo_q + YOW'(1);
            end else begin
              yo_d = '0;
              c_d  = c_q + CW'(1);
            end
          end
        end
      end
    end

    // Read one cycle ahead at the next counter values so m_data is ready with no bubble.
    rd_addr = AW'(((int'(c_d) * R * R + int'(yi_d) * R + int'(xi_d)) * IN_HEIGHT
                   + int'(yo_d)) * IN_WIDTH + int'(xo_d));
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt_q] <= s_data;
    // Forward a same-cycle write so a frame of one word still reads correctly.
    if (wr_en && (wr_cnt_q == rd_addr)) rd_data_q <= s_data;
    else                                rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      wr_cnt_q <= '0;
      c_q      <= '0;
      yo_q     <= '0;
      yi_q     <= '0;
      xo_q     <= '0;
      xi_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      c_q      <= c_d;
      yo_q     <= yo_d;
      yi_q     <= yi_d;
      xo_q     <= xo_d;
      xi_q     <= xi_d;
      err_q    <= err_d;
    end
  end

  assign m_data = rd_data_q;
  assign err    = err_q;

endmodule

// File: tb/tb_pixel_shuffle_stream.sv
`timescale 1ns/1ps
// Scoreboard bench for pixel_shuffle_stream: directed frames push expected words,
// independent monitors pop and compare on every output handshake.
module tb_pixel_shuffle_stream;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, s_valid, s_ready, s_last, m_valid, m_ready, m_last, frame_done, err;
  logic [DW-1:0] s_data, m_data;
  logic          s_valid2, s_ready2, s_last2, m_valid2, m_ready2, m_last2, frame_done2, err2;
  logic [DW-1:0] s_data2, m_data2;

  pixel_shuffle_stream #(.OUT_CHANNELS(1), .IN_HEIGHT(2), .IN_WIDTH(2), .R(2), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_done(frame_done), .err(err));

  pixel_shuffle_stream #(.OUT_CHANNELS(2), .IN_HEIGHT(2), .IN_WIDTH(2), .R(2), .DATA_WIDTH(DW)) dut2 (
    .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2), .s_last(s_last2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_last(m_last2),
    .frame_done(frame_done2), .err(err2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;
  exp_t exp_q[$];

  int in_base[16]  = '{1, 2, 3, 4,  2, 4, 6, 8,  3, 6, 9, 12,  4, 8, 12, 16};
  int out_exp[16]  = '{1, 2, 2, 4,  3, 4, 6, 8,  3, 6, 4, 8,  9, 12, 12, 16};
  int oc2_exp[4]   = '{16, 20, 17, 21};

  int   ready_mode = 0;
  int   rcnt       = 0;
  int   out_cnt    = 0;
  int   idx2       = 0;
  logic err_exp    = 1'b0;

  // Downstream ready pattern: always 1, or repeating 1,0,0,1.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) m_ready = 1'b1;
      else begin
        m_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
        rcnt++;
      end
    end
  end

  // Monitor for the main DUT.
  initial begin
    logic          held_v;
    logic [DW-1:0] held_d;
    logic          held_l;
    exp_t          e;
    held_v = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, held_d);
          check("stall_last", m_last, held_l);
        end
        if (m_valid) check("s_ready_in_drain", s_ready, 0);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got data %0d, required no output", m_data);
          end else begin
            e = exp_q.pop_front();
            $display("out #%0d data=%0d last=%0d", out_cnt, m_data, m_last);
            check("m_data", m_data, e.d);
            check("m_last", m_last, e.l);
            check("frame_done", frame_done, e.l);
          end
          out_cnt++;
        end else begin
          check("frame_done_idle", frame_done, 0);
        end
        held_v = m_valid && !m_ready;
        held_d = m_data;
        held_l = m_last;
      end
    end
  end

  // Monitor for the two-output-channel instance.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && m_valid2 && m_ready2) begin
        $display("oc2 out #%0d data=%0d last=%0d", idx2, m_data2, m_last2);
        if (idx2 >= 16 && idx2 <= 19) check("oc2_data", m_data2, oc2_exp[idx2-16]);
        check("oc2_last", m_last2, (idx2 == 31));
        idx2++;
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input int i);
    int   t;
    logic acc;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 300);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL s_ready_timeout: beat %0d not accepted within 300 cycles", i);
    end
    if (l != (i == 15)) err_exp = 1'b1;
    check("err", err, err_exp);
  endtask

  task automatic send_frame(input int off, input int last_at);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.d = DW'(out_exp[i] + off);
      e.l = (i == 15);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 16; i++) send_beat(DW'(in_base[i] + off), (i == last_at), i);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    s_valid2 = 1'b0; s_data2 = '0; s_last2 = 1'b0; m_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;

    // Basic frame with latency check.
    send_frame(0, 15);
    @(negedge clk);
    check("latency_m_valid", m_valid, 1);
    wait_drain();

    // Backpressure 1,0,0,1.
    ready_mode = 1;
    rcnt = 0;
    send_frame(0, 15);
    wait_drain();
    ready_mode = 0;

    // Back-to-back frames with s_valid held across A's drain.
    send_frame(0, 15);
    send_frame(100, 15);
    wait_drain();

    // Early s_last on beat 7: err sticky, frame still 16 beats.
    send_frame(0, 7);
    wait_drain();
    check("err_sticky", err, 1);

    // Reset after five outputs of a draining frame.
    send_frame(0, 15);
    begin
      int tgt;
      tgt = out_cnt + 5;
      t = 0;
      while (out_cnt < tgt && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      check("mid_drain_outputs", out_cnt, tgt);
    end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    check("post_rst_m_valid", m_valid, 0);
    check("post_rst_s_ready", s_ready, 1);
    check("post_rst_err", err, 0);
    @(posedge clk); #1;
    send_frame(0, 15);
    wait_drain();
    check("fresh_err", err, 0);

    // Two output channels, inputs 0..31.
    for (int i = 0; i < 32; i++) begin
      logic acc;
      s_valid2 = 1'b1;
      s_data2  = DW'(i);
      s_last2  = (i == 31);
      t = 0;
      do begin
        @(negedge clk);
        acc = s_ready2;
        @(posedge clk); #1;
        t++;
      end while (!acc && t < 300);
      if (!acc) begin
        n_checks++;
        n_fail++;
        $display("FAIL oc2_s_ready_timeout: beat %0d not accepted", i);
      end
    end
    s_valid2 = 1'b0;
    s_last2  = 1'b0;
    t = 0;
    while (idx2 < 32 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("oc2_count", idx2, 32);
    check("oc2_err", err2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
